// File: rtl/jedro_1_cpu_top.sv
// jedro_1: multi-cycle, non-pipelined RV32I-subset core with a 32x32 register file.
// Unsupported encodings retire as NOPs (PC+4).

module jedro_1_regfile #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [4:0]            raddr_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [4:0]            raddr_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o
);
  logic [DATA_WIDTH-1:0] regfile [0:31];

  // Register writes; x0 is never written so it stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regfile[waddr_i] <= wdata_i;
    end
  end

  // Combinational reads with x0 hardwired to zero.
  always_comb begin
    rdata_a_o = (raddr_a_i == 5'd0) ? '0 : regfile[raddr_a_i];
    rdata_b_o = (raddr_b_i == 5'd0) ? '0 : regfile[raddr_b_i];
  end
endmodule

module jedro_1_cpu_top #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic                  imem_rd_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic                  dmem_rd_o,
  output logic                  dmem_we_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);
  typedef enum logic [1:0] {StFetch, StExec, StMem} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic [DATA_WIDTH-1:0] dwdata_q, dwdata_d;
  logic [4:0]            ld_rd_q, ld_rd_d;
  logic                  imem_rd, dmem_rd, dmem_we;

  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata, rs1_val, rs2_val;

  logic [31:0] instr, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        taken;

  assign instr  = imem_rdata_i;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  jedro_1_regfile #(.DATA_WIDTH(DATA_WIDTH)) regfile_inst (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rs1),
    .rdata_a_o (rs1_val),
    .raddr_b_i (rs2),
    .rdata_b_o (rs2_val)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    unique case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Branch condition for the current instruction.
  always_comb begin
    unique case (funct3)
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val < rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // Next-state, decode/execute, writeback and memory strobes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    iaddr_d  = iaddr_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    ld_rd_d  = ld_rd_q;
    imem_rd  = 1'b0;
    dmem_rd  = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = '0;
    unique case (state_q)
      StFetch: begin
        imem_rd = 1'b1;
        iaddr_d = pc_q;
        state_d = StExec;
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_q + 32'd4;
        unique case (opcode)
          7'b0110111: begin rf_we = 1'b1; rf_wdata = imm_u; end
          7'b0010111: begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
          7'b1101111: begin
            rf_we    = 1'b1;
            rf_wdata = pc_q + 32'd4;
            pc_d     = (pc_q + imm_j) & ~32'd3;
          end
          7'b1100111: if (funct3 == 3'b000) begin
            rf_we    = 1'b1;
            rf_wdata = pc_q + 32'd4;
            pc_d     = (rs1_val + imm_i) & ~32'd3;
          end
          7'b1100011: if (taken) pc_d = (pc_q + imm_b) & ~32'd3;
          7'b0010011: begin
            if (funct3 == 3'b001) begin
              rf_we = (funct7 == 7'h00);
            end else if (funct3 == 3'b101) begin
              rf_we = (funct7 == 7'h00) || (funct7 == 7'h20);
            end else begin
              rf_we = 1'b1;
            end
            rf_wdata = alu(rs1_val, imm_i, funct3, (funct3 == 3'b101) && funct7[5]);
          end
          7'b0110011: begin
            rf_we    = (funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            rf_wdata = alu(rs1_val, rs2_val, funct3, funct7[5]);
          end
          7'b0000011: if (funct3 == 3'b010) begin
            dmem_rd = 1'b1;
            daddr_d = (rs1_val + imm_i) & ~32'd3;
            ld_rd_d = rd;
            pc_d    = pc_q;  // advanced once the load data is written back
            state_d = StMem;
          end
          7'b0100011: if (funct3 == 3'b010) begin
            dmem_we  = 1'b1;
            daddr_d  = (rs1_val + imm_s) & ~32'd3;
            dwdata_d = rs2_val;
          end
          default: ;
        endcase
      end
      StMem: begin
        rf_we    = 1'b1;
        rf_waddr = ld_rd_q;
        rf_wdata = dmem_rdata_i;
        pc_d     = pc_q + 32'd4;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers; address/data registers hold outputs between accesses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StFetch;
      pc_q     <= BOOT_ADDR;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      ld_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      iaddr_q  <= iaddr_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      ld_rd_q  <= ld_rd_d;
    end
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    imem_rd_o    = imem_rd & ~rst_i;
    dmem_rd_o    = dmem_rd & ~rst_i;
    dmem_we_o    = dmem_we & ~rst_i;
    imem_addr_o  = rst_i ? '0 : iaddr_d;
    dmem_addr_o  = rst_i ? '0 : daddr_d;
    dmem_wdata_o = rst_i ? '0 : dwdata_d;
  end
endmodule

// File: tb/tb_jedro_1_cpu_top.sv
// Self-checking bench for jedro_1_cpu_top: directed programs plus random programs
// compared against an instruction-level reference model.

module tb_jedro_1_cpu_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata;
  logic [31:0] imem_rdata = '0, dmem_rdata = '0;
  logic        imem_rd, dmem_rd, dmem_we;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:63];

  int          st_cnt = 0;
  logic [31:0] st_addr = '0, st_data = '0;

  localparam logic [31:0] Halt = 32'h0000_006f;  // JAL x0,0

  always #5 clk = ~clk;

  jedro_1_cpu_top dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imem_addr_o  (imem_addr),
    .imem_rd_o    (imem_rd),
    .imem_rdata_i (imem_rdata),
    .dmem_addr_o  (dmem_addr),
    .dmem_rd_o    (dmem_rd),
    .dmem_we_o    (dmem_we),
    .dmem_wdata_o (dmem_wdata),
    .dmem_rdata_i (dmem_rdata)
  );

  // Synchronous memories: data available the cycle after the strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_rdata <= imem[imem_addr[9:2]];
    if (dmem_rd) dmem_rdata <= dmem[dmem_addr[7:2]];
    if (dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
  end

  always @(negedge clk) begin
    if (dmem_we && !rst) begin
      st_cnt  = st_cnt + 1;
      st_addr = dmem_addr;
      st_data = dmem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.regfile_inst.regfile[i];
  endfunction

  // Instruction encoders.
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3,
                                        input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 32'h13);
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = Halt;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a fetch of the given address, sampled at negedges.
  task automatic wait_fetch(input logic [31:0] addr, input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_rd && imem_addr == addr) found = 1;
    end
    chk(tag, {31'b0, found}, 32'd1);
  endtask

  // ---------------- reference model (instruction-set level) ----------------
  logic [31:0] m_x  [0:31];
  logic [31:0] m_dm [0:63];
  logic [31:0] m_pc;

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    return 32'($signed(v << (32 - bits)) >>> (32 - bits));
  endfunction

  task automatic m_wr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 0) m_x[rd] = v;
  endtask

  task automatic m_step();
    logic [31:0] ins, a, b, ii, nxt, ea;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    ins = imem[m_pc[9:2]];
    rd  = ins[11:7];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = sx({20'b0, ins[31:20]}, 12);
    nxt = m_pc + 4;
    case (ins[6:0])
      7'h37: m_wr(rd, {ins[31:12], 12'b0});
      7'h17: m_wr(rd, m_pc + {ins[31:12], 12'b0});
      7'h6f: begin
        m_wr(rd, m_pc + 4);
        nxt = (m_pc + sx({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21)) & ~32'd3;
      end
      7'h67: if (f3 == 0) begin
        m_wr(rd, m_pc + 4);
        nxt = ((a + ii) & ~32'd1) & ~32'd3;
      end
      7'h63: begin
        bit t;
        case (f3)
          0: t = a == b;
          1: t = a != b;
          4: t = $signed(a) < $signed(b);
          5: t = $signed(a) >= $signed(b);
          6: t = a < b;
          7: t = a >= b;
          default: t = 0;
        endcase
        if (t) nxt = (m_pc + sx({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13))
                     & ~32'd3;
      end
      7'h13, 7'h33: begin
        bit is_r = (ins[6:0] == 7'h33);
        logic [31:0] op2 = is_r ? b : ii;
        bit ok;
        bit arith = (f7 == 7'h20);
        if (is_r) ok = (f7 == 0) || (arith && (f3 == 0 || f3 == 5));
        else if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0) || arith;
        else ok = 1;
        if (ok) begin
          case (f3)
            0: m_wr(rd, (is_r && arith) ? a - op2 : a + op2);
            1: m_wr(rd, a << op2[4:0]);
            2: m_wr(rd, ($signed(a) < $signed(op2)) ? 1 : 0);
            3: m_wr(rd, (a < op2) ? 1 : 0);
            4: m_wr(rd, a ^ op2);
            5: m_wr(rd, arith ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0]);
            6: m_wr(rd, a | op2);
            default: m_wr(rd, a & op2);
          endcase
        end
      end
      7'h03: if (f3 == 2) begin ea = a + ii; m_wr(rd, m_dm[ea[7:2]]); end
      7'h23: if (f3 == 2) begin
        ea = a + sx({20'b0, ins[31:25], ins[11:7]}, 12);
        m_dm[ea[7:2]] = b;
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // Random instruction with forward-only control flow toward the halt at index len.
  function automatic logic [31:0] gen(input int idx, input int len);
    int k = $urandom_range(0, 12);
    logic [31:0] rd  = $urandom_range(0, 7);
    logic [31:0] r1  = $urandom_range(0, 7);
    logic [31:0] r2  = $urandom_range(0, 7);
    logic [31:0] f3  = $urandom_range(0, 7);
    logic [31:0] imm = $urandom_range(0, 4095);
    int          rem = len - idx;
    int          off = $urandom_range(1, (rem < 3) ? rem : 3);
    logic [31:0] bf3 [6] = '{0, 1, 4, 5, 6, 7};
    case (k)
      0, 10, 11: begin
        if (f3 == 1) imm[11:5] = 0;
        if (f3 == 5) imm[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return enc_i(imm, r1, f3, rd, 32'h13);
      end
      1, 12: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1)) ? 32'h20 : 32'h0,
                          r2, r1, f3, rd);
      2: return {$urandom(), 12'b0} | {20'b0, rd[4:0], 7'h37};
      3: return {$urandom(), 12'b0} | {20'b0, rd[4:0], 7'h17};
      4: return enc_i(imm, r1, 2, rd, 32'h03);
      5: return enc_s(imm, r2, r1);
      6: return enc_b(off * 4, r2, r1, bf3[$urandom_range(0, 5)]);
      7: return enc_j(off * 4, rd);
      8: return enc_i((idx + off) * 4 + $urandom_range(0, 3), 0, 0, rd, 32'h67);
      default: case ($urandom_range(0, 2))
        0: return 32'h0000_000f;
        1: return enc_i(imm, r1, 0, rd, 32'h03);
        default: return 32'h0000_0073;
      endcase
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    clear_imem();
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    #2 rst = 1'b1;

    // Reset: outputs low, then first fetch from BOOT_ADDR.
    imem[0] = addi(1, 0, 6);
    imem[1] = addi(2, 0, 8);
    imem[2] = enc_r(0, 2, 1, 4, 1);
    imem[3] = enc_r(0, 0, 2, 4, 2);
    imem[4] = enc_i(6, 2, 4, 2, 32'h13);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_strobes", {29'b0, imem_rd, dmem_rd, dmem_we}, 32'd0);
      chk("rst_iaddr", imem_addr, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("boot_rd", {31'b0, imem_rd}, 32'd1);
    chk("boot_addr", imem_addr, 32'd0);
    repeat (32) @(negedge clk);
    chk("xor_x1", rf(1), 32'd14);
    chk("xor_x2", rf(2), 32'd14);

    // Shifts and unsigned compare.
    clear_imem();
    imem[0] = addi(3, 0, -1);
    imem[1] = enc_i(28, 3, 5, 4, 32'h13);
    imem[2] = enc_i(32'h41c, 3, 5, 5, 32'h13);
    imem[3] = enc_r(0, 3, 0, 3, 6);
    reset_dut();
    repeat (16) @(negedge clk);
    chk("srli_x4", rf(4), 32'd15);
    chk("srai_x5", rf(5), 32'hffff_ffff);
    chk("sltu_x6", rf(6), 32'd1);

    // Store then load, with load writeback timing.
    clear_imem();
    imem[0] = addi(1, 0, 32'h55);
    imem[1] = enc_s(8, 1, 0);
    imem[2] = enc_i(8, 0, 2, 7, 32'h03);
    st_cnt = 0;
    reset_dut();
    wait_fetch(32'd8, "lw_fetch_seen");
    chk("sw_count", st_cnt, 32'd1);
    chk("sw_addr", st_addr, 32'd8);
    chk("sw_wdata", st_data, 32'h55);
    repeat (2) @(negedge clk);
    chk("lw_x7_early", rf(7), 32'd0);
    @(negedge clk);
    chk("lw_x7", rf(7), 32'h55);

    // Branch skip and JAL link/target.
    clear_imem();
    imem[0] = addi(1, 0, 1);
    imem[1] = enc_b(8, 0, 1, 1);
    imem[2] = addi(2, 0, 9);
    imem[3] = addi(3, 0, 7);
    imem[4] = enc_j(8, 5);
    imem[5] = addi(6, 0, 1);
    reset_dut();
    repeat (20) @(negedge clk);
    chk("bne_x2", rf(2), 32'd0);
    chk("bne_x3", rf(3), 32'd7);
    chk("jal_x5", rf(5), 32'h14);
    chk("jal_skip_x6", rf(6), 32'd0);
    wait_fetch(32'h18, "jal_target");

    // x0 write discarded; reset during EXEC abandons the instruction.
    clear_imem();
    imem[0] = addi(0, 0, 5);
    imem[1] = addi(9, 0, 3);
    reset_dut();
    wait_fetch(32'd4, "addi_x9_fetch");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midrst_strobes", {29'b0, imem_rd, dmem_rd, dmem_we}, 32'd0);
    @(negedge clk);
    chk("x0_zero", rf(0), 32'd0);
    chk("midrst_x9", rf(9), 32'd0);
    rst = 1'b0;
    #1;
    chk("resume_rd", {31'b0, imem_rd}, 32'd1);
    chk("resume_addr", imem_addr, 32'd0);

    // Random programs against the reference model.
    for (int t = 0; t < 4; t++) begin
      clear_imem();
      for (int i = 0; i < 40; i++) imem[i] = gen(i, 40);
      for (int i = 0; i < 64; i++) begin
        dmem[i] = $urandom();
        m_dm[i] = dmem[i];
      end
      for (int i = 0; i < 32; i++) m_x[i] = '0;
      m_pc = '0;
      for (int s = 0; s < 100 && imem[m_pc[9:2]] != Halt; s++) m_step();
      reset_dut();
      repeat (200) @(negedge clk);
      for (int i = 0; i < 32; i++) chk($sformatf("rand%0d_x%0d", t, i), rf(i), m_x[i]);
      for (int i = 0; i < 64; i++) chk($sformatf("rand%0d_mem%0d", t, i), dmem[i], m_dm[i]);
      wait_fetch(m_pc, $sformatf("rand%0d_halt_pc", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
